// File: rtl/keypad_scan_b3.sv
// =============================================================================
// Module   : keypad_scan_b3
// Brief    : PmodKYPD 4x4 column scanner with per-frame debounce and keycode
//            strobe; auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module keypad_scan_b3 #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] keycode,
    output logic       key_strobe
);

    localparam int                 c_DIV_W    = $clog2(SCAN_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEBOUNCE_SCANS);

    localparam logic [1:0] c_RES_NONE  = 2'd0;
    localparam logic [1:0] c_RES_KEY   = 2'd1;
    localparam logic [1:0] c_RES_MULTI = 2'd2;

    // Indexed by {column slot, row}; slot 0 is col[3], slot 3 is col[0].
    localparam logic [3:0] c_KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    logic [3:0]         r_row_s1;
    logic [3:0]         r_row_s2;
    logic [c_DIV_W-1:0] r_div;
    logic [3:0]         r_col;
    logic [1:0]         r_col_idx;
    logic [1:0]         r_hits;
    logic [3:0]         r_code;
    logic [1:0]         r_cand_kind;
    logic [3:0]         r_cand_code;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_keycode;
    logic               r_strobe;

    logic               w_period_end;
    logic               w_frame_end;
    logic [3:0]         w_row_low;
    logic [2:0]         w_row_cnt;
    logic [1:0]         w_row_sel;
    logic [2:0]         w_hits_sum;
    logic [1:0]         w_hits_next;
    logic [3:0]         w_code_next;
    logic [1:0]         w_res_kind;
    logic               w_same;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [4:0]         w_keycode_next;
    logic               w_press;
    logic               w_rep_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_period_end = (r_div == c_DIV_LAST);
    assign w_frame_end  = w_period_end && (r_col_idx == 2'd3);
    assign w_row_low    = ~r_row_s2;
    assign w_row_cnt    = 3'(w_row_low[0]) + 3'(w_row_low[1])
                        + 3'(w_row_low[2]) + 3'(w_row_low[3]);

    always_comb begin
        w_row_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_row_low[i]) w_row_sel = 2'(i);
        end
    end

    // Hit count saturates at 2: anything beyond one crossing is just "multi".
    always_comb begin
        w_hits_sum  = {1'b0, r_hits} + w_row_cnt;
        w_hits_next = (w_hits_sum > 3'd1) ? 2'd2 : w_hits_sum[1:0];
        w_code_next = (w_row_cnt == 3'd1) ? c_KEY_MAP[{r_col_idx, w_row_sel}] : r_code;
        case (w_hits_next)
            2'd0:    w_res_kind = c_RES_NONE;
            2'd1:    w_res_kind = c_RES_KEY;
            default: w_res_kind = c_RES_MULTI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= '0;
            r_col     <= 4'b0111;
            r_col_idx <= 2'd0;
            r_hits    <= 2'd0;
            r_code    <= 4'h0;
        end else if (w_period_end) begin
            r_div     <= '0;
            r_col     <= {r_col[0], r_col[3:1]};
            r_col_idx <= r_col_idx + 2'd1;
            if (w_frame_end) begin
                r_hits <= 2'd0;
                r_code <= 4'h0;
            end else begin
                r_hits <= w_hits_next;
                r_code <= w_code_next;
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Multi-key frames never commit, so a ghosted chord leaves the key alone.
    always_comb begin
        w_same = (w_res_kind == r_cand_kind) &&
                 ((w_res_kind != c_RES_KEY) || (w_code_next == r_cand_code));
        if (!w_same)               w_cnt_next = c_CNT_W'(1);
        else if (r_cnt == c_CNT_MAX) w_cnt_next = r_cnt;
        else                       w_cnt_next = r_cnt + 1'b1;

        w_keycode_next = r_keycode;
        if (w_cnt_next == c_CNT_MAX) begin
            if (w_res_kind == c_RES_NONE)     w_keycode_next = 5'h00;
            else if (w_res_kind == c_RES_KEY) w_keycode_next = {1'b1, w_code_next};
        end
        w_press = w_keycode_next[4] && (w_keycode_next != r_keycode);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand_kind <= c_RES_NONE;
            r_cand_code <= 4'h0;
            r_cnt       <= '0;
            r_keycode   <= 5'h00;
            r_strobe    <= 1'b0;
        end else begin
            r_strobe <= w_frame_end && (w_press || w_rep_fire);
            if (w_frame_end) begin
                r_cand_kind <= w_res_kind;
                r_cand_code <= w_code_next;
                r_cnt       <= w_cnt_next;
                r_keycode   <= w_keycode_next;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_armed;
    logic [c_REP_W-1:0] w_rep_inc;

    // First repeat waits REPEAT_DELAY frames, later ones REPEAT_RATE frames.
    always_comb begin
        w_rep_inc  = r_rep_cnt + 1'b1;
        w_rep_fire = 1'b0;
        if (r_keycode[4] && (w_keycode_next == r_keycode)) begin
            w_rep_fire = r_rep_armed ? (w_rep_inc == c_REP_W'(REPEAT_RATE))
                                     : (w_rep_inc == c_REP_W'(REPEAT_DELAY));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_frame_end) begin
            if (w_keycode_next != r_keycode) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
            end else if (r_keycode[4]) begin
                if (w_rep_fire) begin
                    r_rep_cnt   <= '0;
                    r_rep_armed <= 1'b1;
                end else begin
                    r_rep_cnt <= w_rep_inc;
                end
            end
        end
    end
`else
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_DELAY + REPEAT_RATE) > 0;
    assign w_rep_fire      = 1'b0;
`endif

    assign col        = r_col;
    assign keycode    = r_keycode;
    assign key_strobe = r_strobe;

endmodule

`default_nettype wire
